// File: rtl/dds_sum_array_pkg.sv
// dds_pkg: shared constants and helpers for the DDS summing array.
//   AMP_FRAC     - fractional bits of the amplitude multiply (Q1.15)
//   SINE_W       - sine ROM sample width
//   tree_levels  - adder tree depth for a given channel count
//   sine_entry   - elaboration-time sine ROM contents
//   clamp_s      - signed saturation to a given width
package dds_pkg;

  localparam int unsigned AMP_FRAC = 15;
  localparam int unsigned SINE_W   = 16;
  localparam real         DDS_PI   = 3.14159265358979323846;

  function automatic int unsigned tree_levels(int unsigned nch);
    return $clog2(nch);
  endfunction

  // round(32767 * sin(2*pi*i / 2^lut_aw)), halves rounded away from zero
  function automatic logic signed [SINE_W-1:0] sine_entry(int unsigned lut_aw, int unsigned i);
    real r;
    r = 32767.0 * $sin(2.0 * DDS_PI * real'(i) / real'(1 << lut_aw));
    if (r >= 0.0)
      return SINE_W'($rtoi(r + 0.5));
    return SINE_W'(-$rtoi(0.5 - r));
  endfunction

  // Saturate v to the signed range of a w-bit word
  function automatic longint clamp_s(longint v, int unsigned w);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
    if (v > hi)
      return hi;
    if (v < lo)
      return lo;
    return v;
  endfunction

endpackage

// File: rtl/dds_sum_array_if.sv
// dds_sum_array_if: control/sample bus of the DDS summing array.
//   amps/offsets/phasewords - per-channel settings, channel k at [k*W +: W]
//   chan_en                 - per-channel enable
//   activein                - advance accumulators, sample valid
//   results/activeout/ovf   - saturated sum, its valid flag, clamp flag
// master drives the settings, slave (the DDS array) drives the results.
interface dds_sum_array_if #(
  parameter int unsigned NCH = 4,
  parameter int unsigned PW  = 16,
  parameter int unsigned AW  = 16,
  parameter int unsigned OW  = 16
);

  logic [NCH*AW-1:0]    amps;
  logic [NCH*PW-1:0]    offsets;
  logic [NCH*PW-1:0]    phasewords;
  logic [NCH-1:0]       chan_en;
  logic                 activein;
  logic signed [OW-1:0] results;
  logic                 activeout;
  logic                 ovf;

  modport master (
    output amps, offsets, phasewords, chan_en, activein,
    input  results, activeout, ovf
  );

  modport slave (
    input  amps, offsets, phasewords, chan_en, activein,
    output results, activeout, ovf
  );

endinterface

// File: rtl/dds_sum_array_channel.sv
// dds_channel: one DDS channel - phase accumulator, offset, sine ROM and
// amplitude scaling, three registered stages from sample to product.
//   clk, reset (async, active low)
//   phase_sync  - (DDS_SUM_PHASE_SYNC_EN only) zero the accumulator
//   phaseword   - phase increment, applied when activein=1
//   offset      - phase offset added before the ROM lookup
//   amp         - signed Q1.15 amplitude
//   en          - channel enable, 0 forces the product to 0
//   activein    - advance the accumulator
//   p           - registered, saturated channel product
module dds_channel
  import dds_pkg::*;
#(
  parameter int unsigned PW     = 16,
  parameter int unsigned AW     = 16,
  parameter int unsigned LUT_AW = 10
) (
  input  logic                     clk,
  input  logic                     reset,
`ifdef DDS_SUM_PHASE_SYNC_EN
  input  logic                     phase_sync,
`endif
  input  logic [PW-1:0]            phaseword,
  input  logic [PW-1:0]            offset,
  input  logic signed [AW-1:0]     amp,
  input  logic                     en,
  input  logic                     activein,
  output logic signed [SINE_W-1:0] p
);

  localparam int DEPTH = 1 << LUT_AW;

  logic signed [SINE_W-1:0] sine_rom [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    localparam logic signed [SINE_W-1:0] VAL = sine_entry(LUT_AW, g);
    assign sine_rom[g] = VAL;
  end

  logic [PW-1:0]            acc;
  logic [PW-1:0]            phase_sum;
  logic [LUT_AW-1:0]        idx_q;
  logic                     en1_q, en2_q;
  logic signed [AW-1:0]     amp1_q, amp2_q;
  logic signed [SINE_W-1:0] s_q;
  logic signed [SINE_W-1:0] p_next;
  longint                   prod;
  longint                   prod_sh;

  // Lookup uses the accumulator value before this cycle's increment
  assign phase_sum = acc + offset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
`ifdef DDS_SUM_PHASE_SYNC_EN
    end else if (phase_sync) begin
      acc <= '0;
`endif
    end else if (activein) begin
      acc <= acc + phaseword;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q  <= '0;
      en1_q  <= 1'b0;
      amp1_q <= '0;
      s_q    <= '0;
      en2_q  <= 1'b0;
      amp2_q <= '0;
      p      <= '0;
    end else begin
      idx_q  <= phase_sum[PW-1 -: LUT_AW];
      en1_q  <= en;
      amp1_q <= amp;
      s_q    <= sine_rom[idx_q];
      en2_q  <= en1_q;
      amp2_q <= amp1_q;
      p      <= p_next;
    end
  end

  always_comb begin
    prod    = longint'(s_q) * longint'(amp2_q);
    prod_sh = prod >>> AMP_FRAC;
    p_next  = '0;
    if (en2_q)
      p_next = SINE_W'(clamp_s(prod_sh, SINE_W));
  end

endmodule

// File: rtl/dds_sum_array.sv
// dds_sum_array: NCH DDS channels summed by a registered adder tree and
// saturated to one OW-bit signed sample. Latency LAT = 3 + log2(NCH) + 1.
//   clk, reset (async, active low)
//   phase_sync - present only with `define DDS_SUM_PHASE_SYNC_EN; zeroes
//                every accumulator on the next edge
//   bus        - dds_sum_array_if.slave: per-channel settings in,
//                results/activeout/ovf out
module dds_sum_array
  import dds_pkg::*;
#(
  parameter int unsigned NCH    = 4,
  parameter int unsigned PW     = 16,
  parameter int unsigned AW     = 16,
  parameter int unsigned LUT_AW = 10,
  parameter int unsigned OW     = 16
) (
  input  logic            clk,
  input  logic            reset,
`ifdef DDS_SUM_PHASE_SYNC_EN
  input  logic            phase_sync,
`endif
  dds_sum_array_if.slave  bus
);

  localparam int unsigned L   = tree_levels(NCH);
  localparam int unsigned TW  = SINE_W + L;
  localparam int unsigned LAT = 3 + L + 1;

  logic signed [SINE_W-1:0] chan_p [NCH];

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    dds_channel #(
      .PW     (PW),
      .AW     (AW),
      .LUT_AW (LUT_AW)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
`ifdef DDS_SUM_PHASE_SYNC_EN
      .phase_sync (phase_sync),
`endif
      .phaseword  (bus.phasewords[k*PW +: PW]),
      .offset     (bus.offsets[k*PW +: PW]),
      .amp        (bus.amps[k*AW +: AW]),
      .en         (bus.chan_en[k]),
      .activein   (bus.activein),
      .p          (chan_p[k])
    );
  end

  // Adder tree in heap order: internal node i has children 2i+1 and 2i+2,
  // leaves occupy NCH-1 .. 2*NCH-2. Every internal node is a register, so
  // each level of a power-of-two tree adds one cycle. Nodes are stored at
  // the root width TW; a node on level j only ever carries SINE_W+j
  // significant bits, so the sums cannot overflow.
  logic signed [TW-1:0] sum_q [NCH-1];
  logic signed [TW-1:0] node  [2*NCH-1];

  always_comb begin
    for (int unsigned i = 0; i < NCH - 1; i++)
      node[i] = sum_q[i];
    for (int unsigned k = 0; k < NCH; k++)
      node[NCH-1+k] = TW'(chan_p[k]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NCH - 1; i++)
        sum_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH - 1; i++)
        sum_q[i] <= node[2*i+1] + node[2*i+2];
    end
  end

  // vld[j] is activein delayed by j+1 cycles; vld[LAT-2] lines up with the
  // tree root
  logic [LAT-2:0]       vld;
  longint               sat;
  logic signed [OW-1:0] res_next;
  logic                 ovf_next;

  always_comb begin
    sat      = clamp_s(longint'(sum_q[0]), OW);
    res_next = OW'(sat);
    ovf_next = (sat != longint'(sum_q[0]));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld           <= '0;
      bus.activeout <= 1'b0;
      bus.results   <= '0;
      bus.ovf       <= 1'b0;
    end else begin
      vld           <= {vld[LAT-3:0], bus.activein};
      bus.activeout <= vld[LAT-2];
      if (vld[LAT-2]) begin
        bus.results <= res_next;
        bus.ovf     <= ovf_next;
      end else begin
        bus.results <= '0;
        bus.ovf     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dds_sum_array.sv
// tb_dds_sum_array: directed and random stimulus for dds_sum_array with a
// reference model feeding a scoreboard queue; entries are due LAT cycles
// after the sample that produced them.
module tb_dds_sum_array;

  localparam int unsigned NCH    = 4;
  localparam int unsigned PW     = 16;
  localparam int unsigned AW     = 16;
  localparam int unsigned LUT_AW = 10;
  localparam int unsigned OW     = 16;
  localparam int unsigned LAT    = 6;

  logic clk   = 1'b0;
  logic reset = 1'b1;
`ifdef DDS_SUM_PHASE_SYNC_EN
  logic phase_sync = 1'b0;
`endif

  always #5 clk = ~clk;

  dds_sum_array_if #(.NCH(NCH), .PW(PW), .AW(AW), .OW(OW)) bus ();

  dds_sum_array #(
    .NCH    (NCH),
    .PW     (PW),
    .AW     (AW),
    .LUT_AW (LUT_AW),
    .OW     (OW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef DDS_SUM_PHASE_SYNC_EN
    .phase_sync (phase_sync),
`endif
    .bus        (bus)
  );

  typedef struct {
    logic                 act;
    logic signed [OW-1:0] res;
    logic                 ovf;
  } exp_t;

  exp_t          sb[$];
  logic [PW-1:0] m_acc [NCH];
  int            checks = 0;
  int            errors = 0;
  string         phase_tag = "init";

  task automatic check(string tag, logic signed [31:0] got, logic signed [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s/%s: observed %0d expected %0d", phase_tag, tag, got, exp);
    end
  endtask

  task automatic set_ch(int unsigned k, logic [PW-1:0] ph, logic [PW-1:0] off, logic [AW-1:0] amp);
    bus.phasewords[k*PW +: PW] = ph;
    bus.offsets[k*PW +: PW]    = off;
    bus.amps[k*AW +: AW]       = amp;
  endtask

  task automatic randomize_inputs();
    for (int unsigned k = 0; k < NCH; k++)
      set_ch(k, PW'($urandom), PW'($urandom), AW'($urandom));
    bus.chan_en  = NCH'($urandom);
    bus.activein = 1'($urandom);
  endtask

  function automatic int sine_ref(logic [LUT_AW-1:0] idx);
    return int'(32767.0 * $sin(2.0 * 3.14159265358979323846 * real'(idx) / 1024.0));
  endfunction

  function automatic exp_t model_sample();
    exp_t                 e;
    longint               sum;
    longint               p;
    logic [PW-1:0]        ph;
    logic signed [AW-1:0] a;
    sum = 0;
    for (int unsigned k = 0; k < NCH; k++) begin
      ph = m_acc[k] + bus.offsets[k*PW +: PW];
      a  = bus.amps[k*AW +: AW];
      p  = (longint'(sine_ref(ph[PW-1 -: LUT_AW])) * longint'(a)) >>> 15;
      if (p > 32767)  p = 32767;
      if (p < -32768) p = -32768;
      if (bus.chan_en[k])
        sum += p;
    end
    e.act = bus.activein;
    e.ovf = 1'b0;
    if (sum > 32767) begin
      sum   = 32767;
      e.ovf = 1'b1;
    end else if (sum < -32768) begin
      sum   = -32768;
      e.ovf = 1'b1;
    end
    e.res = OW'(sum);
    if (!bus.activein) begin
      e.res = '0;
      e.ovf = 1'b0;
    end
    return e;
  endfunction

  task automatic pop_check();
    exp_t e;
    e = sb.pop_front();
    check("activeout", bus.activeout, e.act);
    check("results",   bus.results,   e.res);
    check("ovf",       bus.ovf,       e.ovf);
  endtask

  // One clock: record the expected output for the current inputs, advance
  // the model accumulators, then compare whatever is due after the edge
  task automatic cycle(int unsigned n);
    for (int unsigned c = 0; c < n; c++) begin
      sb.push_back(model_sample());
      for (int unsigned k = 0; k < NCH; k++) begin
`ifdef DDS_SUM_PHASE_SYNC_EN
        if (phase_sync)
          m_acc[k] = '0;
        else
`endif
        if (bus.activein)
          m_acc[k] = m_acc[k] + bus.phasewords[k*PW +: PW];
      end
      @(posedge clk);
      #1;
      if (sb.size() >= LAT)
        pop_check();
    end
  endtask

  // Asynchronous reset: outputs must clear without a clock edge and stay
  // clear while held; in-flight samples are discarded
  task automatic do_reset(int unsigned hold);
    exp_t z;
    reset = 1'b0;
    #1;
    check("rst_results",   bus.results,   0);
    check("rst_activeout", bus.activeout, 0);
    check("rst_ovf",       bus.ovf,       0);
    for (int unsigned c = 0; c < hold; c++) begin
      randomize_inputs();
      @(posedge clk);
      #1;
      check("rst_hold_results",   bus.results,   0);
      check("rst_hold_activeout", bus.activeout, 0);
      check("rst_hold_ovf",       bus.ovf,       0);
    end
    bus.activein = 1'b0;
    reset = 1'b1;
    for (int unsigned k = 0; k < NCH; k++)
      m_acc[k] = '0;
    sb.delete();
    z.act = 1'b0;
    z.res = '0;
    z.ovf = 1'b0;
    for (int unsigned i = 0; i < LAT - 1; i++)
      sb.push_back(z);
  endtask

  initial begin
    randomize_inputs();
    #2;
    phase_tag = "reset";
    do_reset(3);
    cycle(8);

    // DC on channel 0 at the sine peak
    phase_tag = "dc_single";
    for (int unsigned k = 0; k < NCH; k++)
      set_ch(k, PW'($urandom), PW'($urandom), AW'($urandom));
    set_ch(0, 16'h0000, 16'h4000, 16'h7FFF);
    bus.chan_en  = 4'b0001;
    bus.activein = 1'b1;
    cycle(10);

    phase_tag = "sat_pos";
    for (int unsigned k = 0; k < NCH; k++)
      set_ch(k, 16'h0000, 16'h4000, 16'h7FFF);
    bus.chan_en = 4'hF;
    cycle(8);

    phase_tag = "sat_neg";
    for (int unsigned k = 0; k < NCH; k++)
      set_ch(k, 16'h0000, 16'hC000, 16'h7FFF);
    cycle(8);

    // Quarter-turn steps on channel 0: 0, 32766, 0, -32767, ...
    phase_tag = "wrap";
    do_reset(1);
    set_ch(0, 16'h4000, 16'h0000, 16'h7FFF);
    bus.chan_en  = 4'b0001;
    bus.activein = 1'b1;
    cycle(12);

    phase_tag = "gap";
    bus.activein = 1'b0;
    cycle(3);
    bus.activein = 1'b1;
    cycle(10);

    phase_tag = "midreset";
    do_reset(2);
    set_ch(0, 16'h4000, 16'h0000, 16'h7FFF);
    bus.chan_en  = 4'b0001;
    bus.activein = 1'b1;
    cycle(12);

`ifdef DDS_SUM_PHASE_SYNC_EN
    phase_tag = "phase_sync";
    cycle(1);
    phase_sync = 1'b1;
    cycle(1);
    phase_sync = 1'b0;
    cycle(10);
`endif

    phase_tag = "random";
    for (int unsigned r = 0; r < 40; r++) begin
      randomize_inputs();
      cycle(1);
    end

    phase_tag = "drain";
    bus.activein = 1'b0;
    cycle(LAT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dds_sum_array.md
Name: dds_sum_array

Overview:
- Parametrised successor to the fixed two-channel DDS summer: NCH direct-digital-synthesis channels, each with phase accumulator, phase offset, sine ROM and amplitude multiply.
- Channel outputs are combined in a registered, bit-growing adder tree and saturated to one signed output sample.
- Adds per-channel enable, an overflow flag and a fixed, documented end-to-end latency.
- Sits between the register/control front end and the DAC output stage.

Parameters:
- NCH, 4, channel count; power of two, 2..16.
- PW, 16, phase accumulator / phaseword / offset width.
- AW, 16, signed amplitude width per channel.
- LUT_AW, 10, sine ROM address width; index = top LUT_AW bits of phase.
- OW, 16, signed output sample width.

Ports:
- clk  in  1  system clock; all state rises on posedge.
- reset  in  1  asynchronous, active-low reset.
- amps  in  NCH*AW  signed amplitude; channel k = amps[k*AW +: AW].
- offsets  in  NCH*PW  phase offset per channel, same slicing.
- phasewords  in  NCH*PW  phase increment per channel, same slicing.
- chan_en  in  NCH  per-channel enable; 0 = channel contributes 0.
- activein  in  1  advance accumulators and mark the sample valid.
- results  out  OW  signed saturated sum.
- activeout  out  1  results valid.
- ovf  out  1  high when results was clamped; aligned with results.

Behaviour:
- Reset (reset=0): asynchronously clears all accumulators, pipeline registers, results, activeout and ovf to 0. Reset mid-stream drops in-flight samples; the first valid output after release is exactly LAT cycles after the first activein=1.
- Accumulator: acc_k <= acc_k + phaseword_k (mod 2^PW) on each clk where activein=1; held otherwise. Wrap-around is silent.
- Channel stage 1: register idx_k = (acc_k + offset_k)[PW-1 -: LUT_AW] using pre-update acc_k; also register chan_en_k and amp_k.
- Channel stage 2: register s_k = SINE[idx_k], where SINE[i] = round(32767*sin(2*pi*i/2^LUT_AW)), signed 16-bit.
- Channel stage 3: p_k = (s_k * amp_k) >>> 15 (arithmetic), clamped to the signed 16-bit range and registered. Forced to 0 if the registered enable is 0.
- Adder tree: L = log2(NCH) registered levels; each level sums pairs and grows width by 1 bit. No overflow is possible inside the tree.
- Output stage: clamp the tree sum to [-2^(OW-1), 2^(OW-1)-1]. Register results and register ovf = clamp occurred.
- If the delayed activein is 0, results <= 0 and ovf <= 0.
- Latency: LAT = 3 + L + 1 cycles (6 for NCH=4). activeout = activein delayed by LAT.
- The pipeline advances every cycle with no stall. Gaps in activein propagate as bubbles of equal length.
- Inputs are sampled every cycle and may change at any time; changes take effect on the next sample.

Optional Feature:
- Macro DDS_SUM_PHASE_SYNC_EN.
- When defined: adds input port phase_sync (1 bit). When phase_sync=1, all accumulators load 0 on the next edge, taking priority over the activein increment; the pipeline is not flushed.
- When undefined: the port and its logic are absent, and accumulators change only via activein and reset.

Decomposition:
- Shared package dds_pkg holds:
  - SINE ROM init function/constant;
  - amplitude shift constant AMP_FRAC=15;
  - clamp helper function;
  - a localparam-style function for L = clog2(NCH).
- Natural sub-module: dds_channel (accumulator + stages 1–3), instantiated NCH times via generate. The adder tree and output saturation stay in the top.

Test Plan:
- Reset: hold reset=0 with random inputs -> results=0, activeout=0, ovf=0. Release with activein=0 -> outputs remain 0.
- DC single channel (NCH=4): ch0 offset=0x4000, phaseword=0, amp=0x7FFF, chan_en=4'b0001, activein=1 from cycle 0 -> activeout rises at cycle 6; results=32766, ovf=0.
- Saturation: all four channels configured as above, chan_en=4'hF -> results=32767, ovf=1. Change offsets to 0xC000 -> per-channel -32767, results=-32768, ovf=1.
- Wrap-around: ch0 phaseword=0x4000, offset=0, amp=0x7FFF, others disabled -> results repeat 0, 32766, 0, -32767 with period 4.
- Gating and reset: in the wrap test, drop activein for 3 cycles -> activeout low for exactly 3 cycles LAT later and the sequence resumes with no skipped phase. Assert reset mid-stream -> all outputs 0 asynchronously, with no stale sample after release.
- With DDS_SUM_PHASE_SYNC_EN: pulse phase_sync while the wrap test runs -> LAT+1 cycles later the sequence restarts at 0, 32766, ...
